reg_bank_reader: RTL and testbench

Read-side sequencer for the generated register bank. Accepts burst read commands (start index, word count) and streams the selected register contents out one word per cycle over a valid/ready handshake, with wrap-around indexing. Sits between the flattened bank output vector and a downstream consumer, such as a monitor or bus responder. It complements the existing per-register write path.

---
 rtl/reg_bank_pkg.sv | 18 +
 rtl/reg_bank_rd_mux.sv | 27 ++
 rtl/reg_bank_reader.sv | 126 ++++++++++++
 tb/tb_reg_bank_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types, defaults and index helper for the register bank read path.
package reg_bank_pkg;

  localparam int REG_BANK_NUM_REGS = 2;
  localparam int REG_BANK_DW       = 2;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } rd_state_e;

  // Next index in a bank of num_regs entries, wrapping to 0 after the last one.
  function automatic int unsigned wrap_next_idx(input int unsigned idx,
                                                input int unsigned num_regs);
    return (idx == num_regs - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_bank_rd_mux.sv
// Combinational register select: picks one DW-bit word out of the flattened bank.
module reg_bank_rd_mux #(
  parameter int NUM_REGS = 2,
  parameter int DW       = 2,
  parameter int AW       = 1
) (
  input  logic [NUM_REGS*DW-1:0] i_bank_q,
  input  logic [AW-1:0]          i_idx,
  output logic [DW-1:0]          o_word
);

  localparam int DEPTH = 1 << AW;

  // Indices past the last register read as zero so the select is total.
  logic [DW-1:0] w_words [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    if (gi < NUM_REGS) begin : g_real
      assign w_words[gi] = i_bank_q[gi*DW +: DW];
    end else begin : g_pad
      assign w_words[gi] = '0;
    end
  end

  assign o_word = w_words[i_idx];

endmodule

// File: rtl/reg_bank_reader.sv
// Burst read sequencer: streams bank registers one word per cycle with wrap-around.
// Optional macro RD_PARITY_EN adds rd_par, the even parity of rd_data.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter  int NUM_REGS = REG_BANK_NUM_REGS,
  parameter  int DW       = REG_BANK_DW,
  parameter  int LW       = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REGS*DW-1:0] bank_q,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [AW-1:0]          cmd_addr,
  input  logic [LW-1:0]          cmd_len,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DW-1:0]          rd_data,
  output logic [AW-1:0]          rd_idx,
  output logic                   rd_last,
`ifdef RD_PARITY_EN
  output logic                   rd_par,
`endif
  output logic                   busy,
  output logic                   err
);

  localparam logic [AW:0] NUM_LIM = (AW+1)'(NUM_REGS);

  rd_state_e     r_state;
  logic [LW-1:0] r_remaining;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_data;
  logic          r_last;
  logic          r_err;

  logic [AW-1:0] w_next_idx;
  logic [AW-1:0] w_sel_idx;
  logic [DW-1:0] w_word;
  logic          w_cmd_ok;

  assign w_next_idx = AW'(wrap_next_idx(32'(r_idx), NUM_REGS));
  assign w_cmd_ok   = ({1'b0, cmd_addr} < NUM_LIM);

  // In IDLE the mux looks at the incoming command, in STREAM at the next word.
  assign w_sel_idx  = (r_state == S_IDLE) ? cmd_addr : w_next_idx;

  reg_bank_rd_mux #(
    .NUM_REGS (NUM_REGS),
    .DW       (DW),
    .AW       (AW)
  ) u_mux (
    .i_bank_q (bank_q),
    .i_idx    (w_sel_idx),
    .o_word   (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (!w_cmd_ok) begin
              r_err <= 1'b1;
            end else begin
              r_idx       <= cmd_addr;
              r_data      <= w_word;
              r_remaining <= cmd_len;
              r_last      <= (cmd_len == '0);
              r_state     <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (rd_ready) begin
            if (r_last) begin
              r_last  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_idx       <= w_next_idx;
              r_data      <= w_word;
              r_remaining <= r_remaining - LW'(1);
              r_last      <= (r_remaining == LW'(1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef RD_PARITY_EN
  logic r_par;

  // Parity is loaded on exactly the edges that load rd_data, so it tracks the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if ((r_state == S_IDLE && cmd_valid && w_cmd_ok) ||
                 (r_state == S_STREAM && rd_ready && !r_last)) begin
      r_par <= ^w_word;
    end
  end

  assign rd_par = r_par;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  assign rd_valid  = (r_state == S_STREAM);
  assign busy      = (r_state == S_STREAM);
  assign rd_data   = r_data;
  assign rd_idx    = r_idx;
  assign rd_last   = r_last;
  assign err       = r_err;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed bench for reg_bank_reader: a 4-register and a 3-register instance.
module tb_reg_bank_reader;

  localparam int DW = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-register instance
  logic [4*DW-1:0] bank4;
  logic            cmd4_valid, cmd4_ready, rd4_valid, rd4_ready, rd4_last, busy4, err4;
  logic [1:0]      cmd4_addr, rd4_idx;
  logic [LW-1:0]   cmd4_len;
  logic [DW-1:0]   rd4_data;
  // 3-register instance
  logic [3*DW-1:0] bank3;
  logic            cmd3_valid, cmd3_ready, rd3_valid, rd3_ready, rd3_last, busy3, err3;
  logic [1:0]      cmd3_addr, rd3_idx;
  logic [LW-1:0]   cmd3_len;
  logic [DW-1:0]   rd3_data;
`ifdef RD_PARITY_EN
  logic            rd4_par, rd3_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  reg_bank_reader #(.NUM_REGS(4), .DW(DW), .LW(LW)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank_q    (bank4),
    .cmd_valid (cmd4_valid),
    .cmd_ready (cmd4_ready),
    .cmd_addr  (cmd4_addr),
    .cmd_len   (cmd4_len),
    .rd_valid  (rd4_valid),
    .rd_ready  (rd4_ready),
    .rd_data   (rd4_data),
    .rd_idx    (rd4_idx),
    .rd_last   (rd4_last),
`ifdef RD_PARITY_EN
    .rd_par    (rd4_par),
`endif
    .busy      (busy4),
    .err       (err4)
  );

  reg_bank_reader #(.NUM_REGS(3), .DW(DW), .LW(LW)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bank_q    (bank3),
    .cmd_valid (cmd3_valid),
    .cmd_ready (cmd3_ready),
    .cmd_addr  (cmd3_addr),
    .cmd_len   (cmd3_len),
    .rd_valid  (rd3_valid),
    .rd_ready  (rd3_ready),
    .rd_data   (rd3_data),
    .rd_idx    (rd3_idx),
    .rd_last   (rd3_last),
`ifdef RD_PARITY_EN
    .rd_par    (rd3_par),
`endif
    .busy      (busy3),
    .err       (err3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_word4(input string tag, input logic [7:0] d, input logic [1:0] idx,
                             input logic last);
    check({tag, ".valid"}, 32'(rd4_valid), 32'd1);
    check({tag, ".data"},  32'(rd4_data),  32'(d));
    check({tag, ".idx"},   32'(rd4_idx),   32'(idx));
    check({tag, ".last"},  32'(rd4_last),  32'(last));
    $display("word %s: data=%02h idx=%0d last=%0b", tag, rd4_data, rd4_idx, rd4_last);
  endtask

  task automatic send4(input logic [1:0] addr, input logic [LW-1:0] len);
    cmd4_valid = 1'b1;
    cmd4_addr  = addr;
    cmd4_len   = len;
    @(negedge clk);
    cmd4_valid = 1'b0;
  endtask

  logic [7:0] exp_d2 [6];
  logic [1:0] exp_i2 [6];
  int         words;
  logic [1:0] last_idx;
  logic [7:0] last_data;

  initial begin
    exp_d2 = '{8'h44, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    exp_i2 = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0;
    bank4 = {8'h44, 8'h33, 8'h22, 8'h11};
    bank3 = {8'hC3, 8'hB2, 8'hA1};
    cmd4_valid = 1'b0; cmd4_addr = '0; cmd4_len = '0; rd4_ready = 1'b1;
    cmd3_valid = 1'b0; cmd3_addr = '0; cmd3_len = '0; rd3_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.rd_valid", 32'(rd4_valid), 32'd0);
    check("rst.busy",     32'(busy4),     32'd0);
    check("rst.err",      32'(err4),      32'd0);
    check("rst.rd_last",  32'(rd4_last),  32'd0);
    check("rst.rd_data",  32'(rd4_data),  32'd0);
    check("rst.rd_idx",   32'(rd4_idx),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.cmd_ready", 32'(cmd4_ready), 32'd1);
    $display("reset released: cmd_ready=%0b", cmd4_ready);

    // 1: addr=1 len=2
    send4(2'd1, 4'd2);
    check("t1.cmd_ready_busy", 32'(cmd4_ready), 32'd0);
    check("t1.busy",           32'(busy4),      32'd1);
    check_word4("t1.w0", 8'h22, 2'd1, 1'b0);
    @(negedge clk); check_word4("t1.w1", 8'h33, 2'd2, 1'b0);
    @(negedge clk); check_word4("t1.w2", 8'h44, 2'd3, 1'b1);
    @(negedge clk);
    check("t1.end_valid", 32'(rd4_valid),  32'd0);
    check("t1.end_ready", 32'(cmd4_ready), 32'd1);

    // 2: addr=3 len=5, wraps twice
    send4(2'd3, 4'd5);
    for (int i = 0; i < 6; i++) begin
      check_word4($sformatf("t2.w%0d", i), exp_d2[i], exp_i2[i], (i == 5));
      @(negedge clk);
    end
    check("t2.end_valid", 32'(rd4_valid), 32'd0);

    // 3: stall with bank change during stall
    rd4_ready = 1'b0;
    send4(2'd0, 4'd1);
    bank4[7:0] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      check_word4($sformatf("t3.stall%0d", i), 8'h11, 2'd0, 1'b0);
      @(negedge clk);
    end
    check_word4("t3.stall3", 8'h11, 2'd0, 1'b0);
    rd4_ready = 1'b1;
    @(negedge clk); check_word4("t3.w1", 8'h22, 2'd1, 1'b1);
    @(negedge clk);
    check("t3.end_valid", 32'(rd4_valid), 32'd0);
    bank4[7:0] = 8'h11;

    // 4: out-of-range address on the 3-register bank
    cmd3_valid = 1'b1; cmd3_addr = 2'd3; cmd3_len = 4'd0;
    @(negedge clk);
    cmd3_valid = 1'b0;
    check("t4.err_pulse", 32'(err3),       32'd1);
    check("t4.no_valid",  32'(rd3_valid),  32'd0);
    check("t4.ready",     32'(cmd3_ready), 32'd1);
    $display("bad cmd: err=%0b rd_valid=%0b", err3, rd3_valid);
    @(negedge clk);
    check("t4.err_clear",  32'(err3),      32'd0);
    check("t4.no_valid2",  32'(rd3_valid), 32'd0);
    cmd3_valid = 1'b1; cmd3_addr = 2'd2; cmd3_len = 4'd1;
    @(negedge clk);
    cmd3_valid = 1'b0;
    check("t4.w0.valid", 32'(rd3_valid), 32'd1);
    check("t4.w0.data",  32'(rd3_data),  32'hC3);
    check("t4.w0.idx",   32'(rd3_idx),   32'd2);
    @(negedge clk);
    check("t4.w1.data",  32'(rd3_data),  32'hA1);
    check("t4.w1.idx",   32'(rd3_idx),   32'd0);
    check("t4.w1.last",  32'(rd3_last),  32'd1);
    $display("wrap on 3 regs: data=%02h idx=%0d last=%0b", rd3_data, rd3_idx, rd3_last);
    @(negedge clk);
    check("t4.end_valid", 32'(rd3_valid), 32'd0);

    // Maximum burst length: 16 words starting at 2, counted with a bound
    send4(2'd2, 4'd15);
    words = 0; last_idx = '0; last_data = '0;
    for (int c = 0; c < 40; c++) begin
      if (rd4_valid) begin
        words++;
        last_idx  = rd4_idx;
        last_data = rd4_data;
        if (rd4_last) break;
      end
      @(negedge clk);
    end
    check("tmax.words",     32'(words),     32'd16);
    check("tmax.last_idx",  32'(last_idx),  32'd1);
    check("tmax.last_data", 32'(last_data), 32'h22);
    $display("max burst: words=%0d last_idx=%0d", words, last_idx);
    @(negedge clk);
    check("tmax.end_valid", 32'(rd4_valid), 32'd0);

    // 5: async reset while the 2nd word of a 4-word burst is presented
    send4(2'd0, 4'd3);
    check_word4("t5.w0", 8'h11, 2'd0, 1'b0);
    @(negedge clk);
    check_word4("t5.w1", 8'h22, 2'd1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5.async_valid", 32'(rd4_valid), 32'd0);
    check("t5.async_busy",  32'(busy4),     32'd0);
    check("t5.async_last",  32'(rd4_last),  32'd0);
    $display("async reset: rd_valid=%0b busy=%0b", rd4_valid, busy4);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5.post%0d.valid", i), 32'(rd4_valid),  32'd0);
      check($sformatf("t5.post%0d.ready", i), 32'(cmd4_ready), 32'd1);
    end

`ifdef RD_PARITY_EN
    // 6: parity
    bank4[15:0] = {8'h03, 8'h07};
    send4(2'd0, 4'd1);
    check("t6.par07", 32'(rd4_par), 32'd1);
    @(negedge clk);
    check("t6.par03", 32'(rd4_par), 32'd0);
    $display("parity: word=%02h rd_par=%0b", rd4_data, rd4_par);
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
